// File: rtl/cache_ctrl.sv
// cache_ctrl
// Direct-mapped, write-through, no-write-allocate controller for a
// 32-line x 128-bit data array. Holds the tag and valid arrays, stalls the
// core on misses and writes, fetches whole lines from main memory on read
// misses and forwards every core write to main memory.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_rd, cpu_wr                  core requests (held while stall=1)
//   cpu_addr, cpu_wdata             core word address and write data
//   stall                           core must hold its request
//   cache_we, cache_wsource         array write enable; 1 = line fill, 0 = word
//   cache_index, cache_word_loc     array line index and word select
//   mem_rd, mem_wr                  level requests to main memory
//   mem_addr, mem_wdata             main-memory word address and write data
//   mem_ready                       main memory completes this cycle
//   hit_count, miss_count           saturating performance counters
module cache_ctrl #(
    parameter int ADDR_W = 12,
    parameter int LINES  = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              stall,
    output logic              cache_we,
    output logic              cache_wsource,
    output logic [4:0]        cache_index,
    output logic [1:0]        cache_word_loc,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = ADDR_W - 7;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t             state, next_state;
    logic [TAG_W-1:0]   tag_ram [LINES];
    logic [LINES-1:0]   valid;
    logic               wr_hit;
    logic [TAG_W-1:0]   addr_tag;
    logic               hit;
    logic               hit_inc, miss_inc;

    assign addr_tag       = cpu_addr[ADDR_W-1:7];
    assign cache_index    = cpu_addr[6:2];
    assign cache_word_loc = cpu_addr[1:0];
    assign mem_wdata      = cpu_wdata;
    assign hit            = valid[cache_index] && (tag_ram[cache_index] == addr_tag);

    always_comb begin
        next_state    = state;
        stall         = 1'b0;
        cache_we      = 1'b0;
        cache_wsource = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = cpu_addr;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        case (state)
            IDLE: begin
                // A simultaneous read and write is handled as a write.
                if (cpu_wr) begin
                    stall      = 1'b1;
                    hit_inc    = hit;
                    miss_inc   = !hit;
                    next_state = WRITE;
                end else if (cpu_rd) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        miss_inc   = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00};
                if (mem_ready) begin
                    // A reset landing on the completion cycle must not write the array.
                    cache_we      = rst_n;
                    cache_wsource = 1'b1;
                    next_state    = DONE;
                end
            end
            WRITE: begin
                stall  = 1'b1;
                mem_wr = 1'b1;
                if (mem_ready) begin
                    // No-write-allocate: only a write hit touches the array.
                    cache_we   = wr_hit && rst_n;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            wr_hit     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && cpu_wr) begin
                wr_hit <= hit;
            end
            if (state == FETCH && mem_ready) begin
                valid[cache_index] <= 1'b1;
            end
            // Counters saturate at all-ones instead of wrapping.
            if (hit_inc && hit_count != {CNT_W{1'b1}}) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc && miss_count != {CNT_W{1'b1}}) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

    // Tags need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rst_n && state == FETCH && mem_ready) begin
            tag_ram[cache_index] <= addr_tag;
        end
    end

endmodule
